pipelined_csel_adder: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor: the next-generation drop-in for the fixed 32-bit combinational carry-select adder. The operand is split into `WIDTH/BLK` blocks. Each block sits in its own pipeline stage and resolves its carry-select with the registered carry of the stage below. A valid/ready handshake with full back-pressure supports throughput of one operation per cycle. Adds subtract mode, carry-in, carry-out and signed overflow.

---
 rtl/pipelined_csel_adder.sv | 89 ++++++++
 tb/tb_pipelined_csel_adder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
// rtl/pipelined_csel_adder.sv - pipelined carry-select adder/subtractor with valid/ready flow control
module pipelined_csel_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    localparam int NBLK = WIDTH / BLK;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign advance = !o_valid || i_ready;
    assign o_ready = advance;
    assign b_eff   = i_sub ? ~i_b : i_b;
    assign c0      = i_sub ? ~i_cin : i_cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, s_in, s_d;
        logic [WIDTH-1:0] a_q, b_q, s_q;
        logic             c_in, v_in, c_d;
        logic             c_q, v_q;
        logic [BLK:0]     sum0, sum1;

        if (k == 0) begin : g_head
            assign a_in = i_a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = c0;
            assign v_in = i_valid;
        end else begin : g_body
            assign a_in = g_stage[k-1].a_q;
            assign b_in = g_stage[k-1].b_q;
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        // Both carry hypotheses are computed up front; only the mux waits on the carry.
        assign sum0 = {1'b0, a_in[k*BLK +: BLK]} + {1'b0, b_in[k*BLK +: BLK]};
        assign sum1 = {1'b0, a_in[k*BLK +: BLK]} + {1'b0, b_in[k*BLK +: BLK]}
                    + {{BLK{1'b0}}, 1'b1};
        assign c_d  = c_in ? sum1[BLK] : sum0[BLK];

        always_comb begin
            s_d                 = s_in;
            s_d[k*BLK +: BLK]   = c_in ? sum1[BLK-1:0] : sum0[BLK-1:0];
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                a_q <= a_in;
                b_q <= b_in;
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_in;
            end
        end
    end

    // Only the sign bits of the operands matter once the last block is resolved.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{g_stage[NBLK-1].a_q, g_stage[NBLK-1].b_q};

    assign o_valid = g_stage[NBLK-1].v_q;
    assign o_sum   = g_stage[NBLK-1].s_q;
    assign o_cout  = g_stage[NBLK-1].c_q;
    assign o_ovf   = (g_stage[NBLK-1].a_q[WIDTH-1] == g_stage[NBLK-1].b_q[WIDTH-1])
                  && (g_stage[NBLK-1].s_q[WIDTH-1] != g_stage[NBLK-1].a_q[WIDTH-1]);
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb/tb_pipelined_csel_adder.sv - scoreboard bench for pipelined_csel_adder
module tb_pipelined_csel_adder;
    logic        clk;
    logic        rst;
    logic        v, icin, isub, rdy;
    logic [31:0] ia, ib;
    logic        o_ready_w, o_valid_w, o_cout_w, o_ovf_w;
    logic [31:0] o_sum_w;

    logic        v16, o_ready16, o_valid16, o_cout16, o_ovf16;
    logic [15:0] a16, b16, o_sum16;
    logic        v8, sub8, o_ready8, o_valid8, o_cout8, o_ovf8;
    logic [7:0]  a8, b8, o_sum8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_mode = 0;

    typedef struct {
        logic [33:0] exp;
        int          acc;
        bit          chk;
    } item_t;
    item_t sb[$];

    pipelined_csel_adder #(.WIDTH(32), .BLK(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(v), .o_ready(o_ready_w),
        .i_a(ia), .i_b(ib), .i_cin(icin), .i_sub(isub),
        .o_valid(o_valid_w), .i_ready(rdy), .o_sum(o_sum_w),
        .o_cout(o_cout_w), .o_ovf(o_ovf_w)
    );

    pipelined_csel_adder #(.WIDTH(16), .BLK(4)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(o_ready16),
        .i_a(a16), .i_b(b16), .i_cin(1'b0), .i_sub(1'b0),
        .o_valid(o_valid16), .i_ready(1'b1), .o_sum(o_sum16),
        .o_cout(o_cout16), .o_ovf(o_ovf16)
    );

    pipelined_csel_adder #(.WIDTH(8), .BLK(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(o_ready8),
        .i_a(a8), .i_b(b8), .i_cin(1'b0), .i_sub(sub8),
        .o_valid(o_valid8), .i_ready(1'b1), .o_sum(o_sum8),
        .o_cout(o_cout8), .o_ovf(o_ovf8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] be;
        logic [32:0] r;
        logic        ovf;
        be  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? ~cin : cin)};
        ovf = (a[31] == be[31]) && (r[31] != a[31]);
        return {r[32], ovf, r[31:0]};
    endfunction

    // Monitor: pops on every output handshake, checks o_ready and stall stability.
    initial begin
        logic [33:0] held;
        logic [33:0] got;
        bit          hold_chk;
        item_t       it;
        hold_chk = 0;
        held     = '0;
        forever begin
            @(negedge clk);
            #2;
            got = {o_cout_w, o_ovf_w, o_sum_w};
            checks++;
            if (o_ready_w !== (!o_valid_w || rdy)) begin
                errors++;
                $display("FAIL o_ready got=%b want=%b", o_ready_w, (!o_valid_w || rdy));
            end
            if (hold_chk) begin
                checks++;
                if (o_valid_w !== 1'b1 || got !== held) begin
                    errors++;
                    $display("FAIL stall_hold got=%b/%h want=1/%h", o_valid_w, got, held);
                end
            end
            hold_chk = o_valid_w && !rdy && !rst;
            held     = got;
            if (o_valid_w && rdy && !rst) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result got=%h want=none", got);
                end else begin
                    it = sb.pop_front();
                    if (got !== it.exp) begin
                        errors++;
                        $display("FAIL result got=%h want=%h", got, it.exp);
                    end
                    if (it.chk) begin
                        checks++;
                        if (cyc - it.acc != 3) begin
                            errors++;
                            $display("FAIL latency got=%0d want=3", cyc - it.acc);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [33:0] exp, input bit chk);
        int    tries;
        item_t it;
        @(negedge clk);
        v = 1'b1; ia = a; ib = b; icin = cin; isub = sub;
        #1;
        tries = 0;
        while (!o_ready_w && tries < 100) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!o_ready_w) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=0 want=1");
        end else begin
            it.exp = exp;
            it.acc = cyc + 1;
            it.chk = chk;
            sb.push_back(it);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        v = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc, rs;
        bit          got16, got8;
        int          acc;
        rst = 1'b1; v = 1'b0; ia = '0; ib = '0; icin = 1'b0; isub = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; v8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
        rdy = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({o_valid_w, o_ready_w, o_cout_w, o_ovf_w, o_sum_w} !== {4'b0100, 32'h0}) begin
            errors++;
            $display("FAIL reset_state got=%b%b%b%b/%h want=0100/00000000",
                     o_valid_w, o_ready_w, o_cout_w, o_ovf_w, o_sum_w);
        end
        rst = 1'b0;

        // Directed vectors, expected {cout, ovf, sum} worked out by hand.
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {2'b10, 32'h00000000}, 1);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {2'b01, 32'h80000000}, 1);
        send(32'h000000FF, 32'h00000001, 1'b1, 1'b0, {2'b00, 32'h00000101}, 1);
        send(32'h00000005, 32'h00000007, 1'b0, 1'b1, {2'b00, 32'hFFFFFFFE}, 1);
        send(32'h80000000, 32'h00000001, 1'b0, 1'b1, {2'b11, 32'h7FFFFFFF}, 1);
        send(32'h0000000A, 32'h00000003, 1'b1, 1'b1, {2'b10, 32'h00000006}, 1);
        send(32'hFFFF00FF, 32'h0000FF01, 1'b0, 1'b0, {2'b10, 32'h00000000}, 1);
        idle();
        drain();

        // Back-pressure with random operands and a reference model.
        rand_mode = 1;
        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs), 0);
        end
        idle();
        drain();
        rand_mode = 0;
        repeat (2) @(negedge clk);

        // Reset mid-flight: none of these may ever emerge.
        send(32'h11111111, 32'h22222222, 1'b0, 1'b0, {2'b00, 32'h33333333}, 1);
        send(32'h44444444, 32'h11111111, 1'b0, 1'b0, {2'b00, 32'h55555555}, 1);
        send(32'h00000009, 32'h00000001, 1'b0, 1'b1, {2'b10, 32'h00000008}, 1);
        @(negedge clk);
        rst = 1'b1; v = 1'b1; ia = 32'h00001234; ib = 32'h1; sb.delete();
        @(negedge clk);
        rst = 1'b0; v = 1'b0;
        #2;
        checks++;
        if ({o_valid_w, o_ready_w, o_sum_w} !== {2'b01, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset got=%b%b/%h want=01/00000000", o_valid_w, o_ready_w, o_sum_w);
        end
        repeat (8) @(negedge clk);
        send(32'h00000100, 32'h00000200, 1'b0, 1'b0, {2'b00, 32'h00000300}, 1);
        idle();
        drain();

        // Parameter sweep: 16/4 (latency 4) and 8/8 (latency 1).
        @(negedge clk);
        v16 = 1'b1; a16 = 16'h0FFF; b16 = 16'h0001;
        v8 = 1'b1; a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1;
        acc = cyc + 1;
        got16 = 0; got8 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            v16 = 1'b0; v8 = 1'b0;
            #2;
            if (o_valid8 && !got8) begin
                got8 = 1;
                checks += 2;
                if ({o_cout8, o_ovf8, o_sum8} !== {2'b11, 8'h7F}) begin
                    errors++;
                    $display("FAIL w8_result got=%b%b/%h want=11/7f", o_cout8, o_ovf8, o_sum8);
                end
                if (cyc - acc != 0) begin
                    errors++;
                    $display("FAIL w8_latency got=%0d want=0", cyc - acc);
                end
            end
            if (o_valid16 && !got16) begin
                got16 = 1;
                checks += 2;
                if ({o_cout16, o_ovf16, o_sum16} !== {2'b00, 16'h1000}) begin
                    errors++;
                    $display("FAIL w16_result got=%b%b/%h want=00/1000", o_cout16, o_ovf16, o_sum16);
                end
                if (cyc - acc != 3) begin
                    errors++;
                    $display("FAIL w16_latency got=%0d want=3", cyc - acc);
                end
            end
        end
        checks++;
        if (!(got8 && got16)) begin
            errors++;
            $display("FAIL sweep_timeout got=%b%b want=11", got8, got16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
